// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
package wb_arb_pkg;

    localparam int WB_ADDR_W = 32;
    localparam int WB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OWN_M0 = 2'd1,
        OWN_M1 = 2'd2,
        TOUT   = 2'd3
    } arb_state_e;

    localparam logic OWNER_M0 = 1'b0;
    localparam logic OWNER_M1 = 1'b1;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_M0   = 2'b01;
    localparam logic [1:0] GRANT_M1   = 2'b10;

endpackage

// File: rtl/wb_arb_watchdog.sv
// Counts strobed cycles without a slave response; flags expiry on the last allowed cycle.
module wb_arb_watchdog
    import wb_arb_pkg::*;
#(
    parameter int TIMEOUT = 256
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic run,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count_r;

    // Wait counter: clear has priority so a response in the expiry cycle wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_r <= '0;
        end else if (clr) begin
            count_r <= '0;
        end else if (run) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = run & (count_r == CNT_LAST);

endmodule

// File: rtl/wb_bus_arbiter.sv
// Round-robin two-master to one-slave Wishbone arbiter with burst hold and hung-access watchdog.
module wb_bus_arbiter
    import wb_arb_pkg::*;
#(
    parameter int ADDR_W  = WB_ADDR_W,
    parameter int DATA_W  = WB_DATA_W,
    parameter int TIMEOUT = 256
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_W-1:0]     m0_adr_i,
    input  logic [DATA_W-1:0]     m0_dat_i,
    input  logic [DATA_W/8-1:0]   m0_sel_i,
    input  logic                  m0_we_i,
    input  logic                  m0_cyc_i,
    input  logic                  m0_stb_i,
    output logic [DATA_W-1:0]     m0_dat_o,
    output logic                  m0_ack_o,
    output logic                  m0_err_o,
    input  logic [ADDR_W-1:0]     m1_adr_i,
    input  logic [DATA_W-1:0]     m1_dat_i,
    input  logic [DATA_W/8-1:0]   m1_sel_i,
    input  logic                  m1_we_i,
    input  logic                  m1_cyc_i,
    input  logic                  m1_stb_i,
    output logic [DATA_W-1:0]     m1_dat_o,
    output logic                  m1_ack_o,
    output logic                  m1_err_o,
    output logic [ADDR_W-1:0]     s_adr_o,
    output logic [DATA_W-1:0]     s_dat_o,
    output logic [DATA_W/8-1:0]   s_sel_o,
    output logic                  s_we_o,
    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    input  logic [DATA_W-1:0]     s_dat_i,
    input  logic                  s_ack_i,
    input  logic                  s_err_i,
    output logic [1:0]            grant_o
);

    arb_state_e state_r;
    logic       last_owner_r;
    logic       wd_run_s;
    logic       wd_clr_s;
    logic       wd_expired_s;

    // s_stb_o is only ever high while a master owns the bus, so idle cycles clear the count.
    assign wd_run_s = s_stb_o & ~s_ack_i & ~s_err_i;
    assign wd_clr_s = ~wd_run_s;

    wb_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (wd_clr_s),
        .run     (wd_run_s),
        .expired (wd_expired_s)
    );

    // Arbitration FSM; last_owner is recorded on leaving ownership so TOUT knows whom to err.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            last_owner_r <= OWNER_M1;
        end else begin
            case (state_r)
                IDLE: begin
                    last_owner_r <= last_owner_r;
                    if (m0_cyc_i && m1_cyc_i) begin
                        state_r <= (last_owner_r == OWNER_M1) ? OWN_M0 : OWN_M1;
                    end else if (m0_cyc_i) begin
                        state_r <= OWN_M0;
                    end else if (m1_cyc_i) begin
                        state_r <= OWN_M1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                OWN_M0: begin
                    if (!m0_cyc_i) begin
                        state_r      <= IDLE;
                        last_owner_r <= OWNER_M0;
                    end else if (wd_expired_s) begin
                        state_r      <= TOUT;
                        last_owner_r <= OWNER_M0;
                    end else begin
                        state_r      <= OWN_M0;
                        last_owner_r <= last_owner_r;
                    end
                end
                OWN_M1: begin
                    if (!m1_cyc_i) begin
                        state_r      <= IDLE;
                        last_owner_r <= OWNER_M1;
                    end else if (wd_expired_s) begin
                        state_r      <= TOUT;
                        last_owner_r <= OWNER_M1;
                    end else begin
                        state_r      <= OWN_M1;
                        last_owner_r <= last_owner_r;
                    end
                end
                TOUT: begin
                    state_r      <= IDLE;
                    last_owner_r <= last_owner_r;
                end
                default: begin
                    state_r      <= IDLE;
                    last_owner_r <= OWNER_M1;
                end
            endcase
        end
    end

    // Bus mux decoded from state so an async reset clears every output at once.
    always_comb begin
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        s_we_o   = 1'b0;
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        m0_dat_o = '0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_dat_o = '0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        grant_o  = GRANT_NONE;
        case (state_r)
            OWN_M0: begin
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_sel_o  = m0_sel_i;
                s_we_o   = m0_we_i;
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i;
                m0_dat_o = s_dat_i;
                m0_ack_o = s_ack_i;
                m0_err_o = s_err_i;
                grant_o  = GRANT_M0;
            end
            OWN_M1: begin
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_sel_o  = m1_sel_i;
                s_we_o   = m1_we_i;
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i;
                m1_dat_o = s_dat_i;
                m1_ack_o = s_ack_i;
                m1_err_o = s_err_i;
                grant_o  = GRANT_M1;
            end
            TOUT: begin
                m0_err_o = (last_owner_r == OWNER_M0);
                m1_err_o = (last_owner_r == OWNER_M1);
            end
            IDLE: begin
                grant_o = GRANT_NONE;
            end
            default: begin
                grant_o = GRANT_NONE;
            end
        endcase
    end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Directed self-checking bench for wb_bus_arbiter (TIMEOUT = 8).
module tb_wb_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [AW-1:0] m0_adr_i, m1_adr_i, s_adr_o;
    logic [DW-1:0] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
    logic [SW-1:0] m0_sel_i, m1_sel_i, s_sel_o;
    logic          m0_we_i, m0_cyc_i, m0_stb_i, m0_ack_o, m0_err_o;
    logic          m1_we_i, m1_cyc_i, m1_stb_i, m1_ack_o, m1_err_o;
    logic          s_we_o, s_cyc_o, s_stb_o, s_ack_i, s_err_i;
    logic [1:0]    grant_o;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    wb_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
        .m0_err_o(m0_err_o),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
        .m1_err_o(m1_err_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
        .s_err_i(s_err_i), .grant_o(grant_o)
    );

    task idle_inputs();
        m0_adr_i = '0; m0_dat_i = '0; m0_sel_i = 4'hF; m0_we_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        m1_adr_i = '0; m1_dat_i = '0; m1_sel_i = 4'hF; m1_we_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        s_dat_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0;
    endtask

    // Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
    task tick();
        @(posedge clk);
        #1;
    endtask

    task settle();
        @(negedge clk);
    endtask

    task apply_reset();
        reset_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;
    endtask

    task test_reset();
        reset_n = 1'b0;
        idle_inputs();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h0000_0055;
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({s_cyc_o, s_stb_o, s_we_o, grant_o} !== 5'b00000)
            $display("FAIL reset_ctrl: got %b expected %b", {s_cyc_o, s_stb_o, s_we_o, grant_o}, 5'b00000);
        else pass_cnt++;
        total_cnt++;
        if ({s_adr_o, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, m0_dat_o, m1_dat_o} !== 100'd0)
            $display("FAIL reset_data: s_adr %h m0_dat %h m1_dat %h expected all 0", s_adr_o, m0_dat_o, m1_dat_o);
        else pass_cnt++;
        idle_inputs();
        #2 reset_n = 1'b1;
    endtask

    task test_single_read();
        tick();
        m0_adr_i = 32'h0000_0010; m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b0;
        settle();
        total_cnt++;
        if ({s_cyc_o, grant_o} !== 3'b000)
            $display("FAIL read_latency: got %b expected %b", {s_cyc_o, grant_o}, 3'b000);
        else pass_cnt++;
        tick(); settle();
        total_cnt++;
        if ({s_cyc_o, s_stb_o, grant_o, s_adr_o} !== {4'b1101, 32'h0000_0010})
            $display("FAIL read_grant: got cyc/stb/grant %b adr %h expected 1101 00000010", {s_cyc_o, s_stb_o, grant_o}, s_adr_o);
        else pass_cnt++;
        tick(); settle();
        tick();
        s_ack_i = 1'b1; s_dat_i = 32'hDEAD_BEEF;
        settle();
        total_cnt++;
        if ({m0_ack_o, m0_dat_o, grant_o} !== {1'b1, 32'hDEAD_BEEF, 2'b01})
            $display("FAIL read_data: got ack %b dat %h grant %b expected 1 deadbeef 01", m0_ack_o, m0_dat_o, grant_o);
        else pass_cnt++;
        total_cnt++;
        if ({m1_ack_o, m1_err_o, m1_dat_o} !== 34'd0)
            $display("FAIL read_m1_quiet: got ack %b err %b dat %h expected 0 0 0", m1_ack_o, m1_err_o, m1_dat_o);
        else pass_cnt++;
        tick();
        s_ack_i = 1'b0; s_dat_i = '0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        settle();
        tick(); settle();
        total_cnt++;
        if ({s_cyc_o, grant_o} !== 3'b000)
            $display("FAIL read_release: got %b expected %b", {s_cyc_o, grant_o}, 3'b000);
        else pass_cnt++;
    endtask

    task test_contention();
        apply_reset();
        tick();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b1; m0_adr_i = 32'h0000_0100; m0_dat_i = 32'h1111_1111;
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b1; m1_adr_i = 32'h0000_0200; m1_dat_i = 32'h2222_2222;
        settle();
        tick();
        s_ack_i = 1'b1;
        settle();
        total_cnt++;
        if ({grant_o, s_we_o, s_dat_o, m0_ack_o, m1_ack_o} !== {2'b01, 1'b1, 32'h1111_1111, 2'b10})
            $display("FAIL cont_m0_first: grant %b dat %h acks %b%b expected 01 11111111 10", grant_o, s_dat_o, m0_ack_o, m1_ack_o);
        else pass_cnt++;
        tick();
        s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        settle();
        tick(); settle();
        total_cnt++;
        if ({s_cyc_o, grant_o} !== 3'b000)
            $display("FAIL cont_dead_cycle: got %b expected %b", {s_cyc_o, grant_o}, 3'b000);
        else pass_cnt++;
        tick();
        s_ack_i = 1'b1;
        settle();
        total_cnt++;
        if ({grant_o, s_adr_o, s_dat_o, m1_ack_o, m0_ack_o} !== {2'b10, 32'h0000_0200, 32'h2222_2222, 2'b10})
            $display("FAIL cont_m1_second: grant %b adr %h dat %h expected 10 00000200 22222222", grant_o, s_adr_o, s_dat_o);
        else pass_cnt++;
        tick();
        s_ack_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        settle();
        tick();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        settle();
        tick(); settle();
        total_cnt++;
        if (grant_o !== 2'b01)
            $display("FAIL cont_rr_again: got %b expected %b", grant_o, 2'b01);
        else pass_cnt++;
        tick();
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        settle();
        tick(); settle();
    endtask

    task test_burst_hold();
        logic [5:0] burst_pat;
        int beats;
        burst_pat = 6'b101101;
        beats = 0;
        tick();
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b0; m1_adr_i = 32'h0000_0300;
        settle();
        for (int i = 0; i < 6; i++) begin
            tick();
            m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b0; m0_adr_i = 32'h0000_0400;
            m1_stb_i = burst_pat[i];
            s_ack_i  = burst_pat[i];
            s_dat_i  = 32'hA000_0000 + 32'(i);
            settle();
            if (m1_ack_o === 1'b1) beats++;
            total_cnt++;
            if ({grant_o, m0_ack_o, m0_err_o, m0_dat_o, m1_ack_o} !== {2'b10, 34'd0, burst_pat[i]})
                $display("FAIL burst_beat%0d: grant %b m0 ack %b dat %h m1 ack %b expected 10 0 0 %b", i, grant_o, m0_ack_o, m0_dat_o, m1_ack_o, burst_pat[i]);
            else pass_cnt++;
        end
        total_cnt++;
        if (beats !== 4)
            $display("FAIL burst_beats: got %0d expected %0d", beats, 4);
        else pass_cnt++;
        tick();
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0; s_ack_i = 1'b0; s_dat_i = '0;
        settle();
        tick(); settle();
        total_cnt++;
        if (grant_o !== 2'b00)
            $display("FAIL burst_dead: got %b expected %b", grant_o, 2'b00);
        else pass_cnt++;
        tick(); settle();
        total_cnt++;
        if ({grant_o, s_adr_o} !== {2'b01, 32'h0000_0400})
            $display("FAIL burst_m0_granted: grant %b adr %h expected 01 00000400", grant_o, s_adr_o);
        else pass_cnt++;
        tick();
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        settle();
        tick(); settle();
    endtask

    task test_timeout();
        tick();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h0000_0500;
        settle();
        for (int i = 0; i < TO; i++) begin
            tick(); settle();
            total_cnt++;
            if ({s_stb_o, m0_err_o} !== 2'b10)
                $display("FAIL tout_wait%0d: stb/err got %b expected %b", i, {s_stb_o, m0_err_o}, 2'b10);
            else pass_cnt++;
        end
        tick();
        s_ack_i = 1'b1;
        settle();
        total_cnt++;
        if ({s_cyc_o, s_stb_o, m0_err_o, m0_ack_o, m1_err_o} !== 5'b00100)
            $display("FAIL tout_err: cyc/stb/err/ack/m1err got %b expected %b", {s_cyc_o, s_stb_o, m0_err_o, m0_ack_o, m1_err_o}, 5'b00100);
        else pass_cnt++;
        tick();
        s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        settle();
        total_cnt++;
        if ({m0_err_o, grant_o, s_cyc_o} !== 4'b0000)
            $display("FAIL tout_idle: got %b expected %b", {m0_err_o, grant_o, s_cyc_o}, 4'b0000);
        else pass_cnt++;
    endtask

    task test_reset_mid_burst();
        tick();
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 32'h0000_0600;
        settle();
        tick(); settle();
        total_cnt++;
        if ({s_cyc_o, s_stb_o, grant_o} !== 4'b1110)
            $display("FAIL rst_pre: got %b expected %b", {s_cyc_o, s_stb_o, grant_o}, 4'b1110);
        else pass_cnt++;
        #2 reset_n = 1'b0;
        #1;
        total_cnt++;
        if ({s_cyc_o, s_stb_o, grant_o} !== 4'b0000)
            $display("FAIL rst_async: got %b expected %b", {s_cyc_o, s_stb_o, grant_o}, 4'b0000);
        else pass_cnt++;
        @(negedge clk);
        #2 reset_n = 1'b1;
        tick(); settle();
        total_cnt++;
        if ({s_cyc_o, grant_o, s_adr_o} !== {3'b110, 32'h0000_0600})
            $display("FAIL rst_regrant: cyc/grant %b adr %h expected 110 00000600", {s_cyc_o, grant_o}, s_adr_o);
        else pass_cnt++;
        tick();
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        settle();
        tick(); settle();
    endtask

    task test_slave_err();
        tick();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b1; m0_adr_i = 32'h0000_0700; m0_dat_i = 32'h1234_5678;
        settle();
        repeat (4) begin
            tick(); settle();
        end
        tick();
        s_err_i = 1'b1;
        settle();
        total_cnt++;
        if ({m0_err_o, m1_err_o, m0_ack_o, grant_o} !== 5'b10001)
            $display("FAIL err_forward: err/m1err/ack/grant got %b expected %b", {m0_err_o, m1_err_o, m0_ack_o, grant_o}, 5'b10001);
        else pass_cnt++;
        for (int i = 0; i < TO - 1; i++) begin
            tick();
            s_err_i = 1'b0;
            settle();
            total_cnt++;
            if ({s_cyc_o, m0_err_o, grant_o} !== 4'b1001)
                $display("FAIL err_no_wdog%0d: cyc/err/grant got %b expected %b", i, {s_cyc_o, m0_err_o, grant_o}, 4'b1001);
            else pass_cnt++;
        end
        tick();
        s_ack_i = 1'b1;
        settle();
        total_cnt++;
        if ({m0_ack_o, m0_err_o} !== 2'b10)
            $display("FAIL err_then_ack: got %b expected %b", {m0_ack_o, m0_err_o}, 2'b10);
        else pass_cnt++;
        tick();
        s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        settle();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_burst_hold();
        test_timeout();
        test_reset_mid_burst();
        test_slave_err();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
